// File: rtl/alu_pkg.sv
// Shared opcode and class encodings for the execute-stage ALU.
// The same two Op bits select different functions depending on the class bit L.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [1:0] OP_NEG_A = 2'b00;
    localparam logic [1:0] OP_NEG_B = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    localparam logic [1:0] OP_AND   = 2'b00;
    localparam logic [1:0] OP_OR    = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam logic [1:0] OP_NOT   = 2'b11;

    localparam logic CLASS_ARITH = 1'b0;
    localparam logic CLASS_LOGIC = 1'b1;

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit ripple-carry adder shared by negate, add and subtract.
// Subtraction and negation reach it as x + ~y + 1 via the operand muxes in the top level.
module alu_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1]   = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
        cout = carry[WIDTH];
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: arithmetic or bitwise result with Z/C/S flags, registered once.
// Handshake: in_valid qualifies A/B/Op/L for one cycle; out_valid pulses the cycle after, no backpressure.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    input  logic             L,
    output logic [WIDTH-1:0] R,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             out_valid
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] next_r;
    logic             next_z;
    logic             next_c;
    logic             next_s;

    // Every arithmetic op is one pass through the adder: negate is 0 + ~op + 1.
    always_comb begin
        add_x   = A;
        add_y   = B;
        add_cin = 1'b0;
        case (Op)
            OP_NEG_A: begin
                add_x   = '0;
                add_y   = ~A;
                add_cin = 1'b1;
            end
            OP_NEG_B: begin
                add_x   = '0;
                add_y   = ~B;
                add_cin = 1'b1;
            end
            OP_ADD: begin
                add_x   = A;
                add_y   = B;
                add_cin = 1'b0;
            end
            OP_SUB: begin
                add_x   = A;
                add_y   = ~B;
                add_cin = 1'b1;
            end
            default: begin
                add_x   = A;
                add_y   = B;
                add_cin = 1'b0;
            end
        endcase
    end

    alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        logic_res = '0;
        case (Op)
            OP_AND:  logic_res = A & B;
            OP_OR:   logic_res = A | B;
            OP_XOR:  logic_res = A ^ B;
            OP_NOT:  logic_res = ~A;
            default: logic_res = '0;
        endcase
    end

    // Logic class never reports carry or sign; zero applies to both classes.
    always_comb begin
        if (L == CLASS_LOGIC) begin
            next_r = logic_res;
            next_c = 1'b0;
            next_s = 1'b0;
        end else begin
            next_r = add_sum;
            next_c = add_cout;
            next_s = add_sum[WIDTH-1];
        end
        next_z = ~|next_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            R         <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            s         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                R <= next_r;
                z <= next_z;
                c <= next_c;
                s <= next_s;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors, reset/hold cases, exhaustive sweep and random traffic.
// Expected {R,z,c,s} come from an integer-arithmetic model and are queued at issue time.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [1:0]   op_in = '0;
    logic         l_in = 1'b0;
    logic [W-1:0] r_out;
    logic         z_out;
    logic         c_out;
    logic         s_out;
    logic         out_valid;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] last_exp = '0;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .Op        (op_in),
        .L         (l_in),
        .R         (r_out),
        .z         (z_out),
        .c         (c_out),
        .s         (s_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: two's-complement results as plain integers modulo 16, carry = sum >= 16.
    function automatic logic [6:0] model(input logic l, input logic [1:0] op,
                                         input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        int v;
        int r;
        logic cf;
        logic sf;
        ai = int'(a);
        bi = int'(b);
        v  = 0;
        if (l) begin
            case (op)
                2'd0: r = int'(a & b);
                2'd1: r = int'(a | b);
                2'd2: r = int'(a ^ b);
                default: r = 15 - ai;
            endcase
            cf = 1'b0;
            sf = 1'b0;
        end else begin
            case (op)
                2'd0: v = 16 - ai;
                2'd1: v = 16 - bi;
                2'd2: v = ai + bi;
                default: v = ai - bi + 16;
            endcase
            r  = v % 16;
            cf = (v >= 16);
            sf = (r >= 8);
        end
        return {r[3:0], (r == 0), cf, sf};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic issue(input logic l, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        l_in     = l;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        last_exp = model(l, op, a, b);
        exp_q.push_back(last_exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a_in     = 4'($urandom_range(0, 15));
            b_in     = 4'($urandom_range(0, 15));
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        logic [6:0] e;
        #1;
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got R=%b z=%b c=%b s=%b with empty queue",
                         r_out, z_out, c_out, s_out);
            end else begin
                e = exp_q.pop_front();
                if ({r_out, z_out, c_out, s_out} !== e) begin
                    errors++;
                    $display("FAIL result: got R=%b z=%b c=%b s=%b expected R=%b z=%b c=%b s=%b",
                             r_out, z_out, c_out, s_out, e[6:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int wait_cycles;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", int'({r_out, z_out, c_out, s_out}), 0);
        check("reset_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(CLASS_ARITH, OP_NEG_A, 4'b0010, 4'b0000);
        issue(CLASS_ARITH, OP_NEG_A, 4'b0000, 4'b0000);
        issue(CLASS_ARITH, OP_ADD,   4'b1001, 4'b1000);
        issue(CLASS_ARITH, OP_SUB,   4'b0011, 4'b0101);
        issue(CLASS_ARITH, OP_SUB,   4'b0101, 4'b0011);
        issue(CLASS_LOGIC, OP_AND,   4'b1100, 4'b0011);
        issue(CLASS_LOGIC, OP_NOT,   4'b1010, 4'b0000);
        issue(CLASS_ARITH, OP_NEG_B, 4'b0111, 4'b0000);

        // Reset with in_valid held high must win over the incoming operation.
        issue(CLASS_ARITH, OP_ADD, 4'b0111, 4'b0110);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        l_in     = CLASS_ARITH;
        op_in    = OP_SUB;
        a_in     = 4'b0001;
        b_in     = 4'b1000;
        @(posedge clk);
        #2;
        check("reset_over_valid_outputs", int'({r_out, z_out, c_out, s_out}), 0);
        check("reset_over_valid_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check("hold_after_reset", int'({r_out, z_out, c_out, s_out}), 0);
            check("hold_after_reset_valid", int'(out_valid), 0);
            if (i == 0) idle(1);
        end

        issue(CLASS_LOGIC, OP_XOR, 4'b1010, 4'b0110);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            @(posedge clk);
            #2;
            check("hold_idle", int'({r_out, z_out, c_out, s_out}), int'(last_exp));
            check("hold_idle_valid", int'(out_valid), 0);
        end

        for (int l = 0; l < 2; l++)
            for (int op = 0; op < 4; op++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        issue(1'(l), 2'(op), 4'(a), 4'(b));

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        idle(1);
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
